// File: rtl/mem_pkg.sv
// Shared definitions for the program/data RAM arbiter: default widths,
// owner-state encoding, requester IDs and the read-return record.
package mem_pkg;

  localparam int AW_DEFAULT = 12;
  localparam int DW_DEFAULT = 16;
  localparam int WAIT_W     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    DBG_OWN = 2'd2
  } owner_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Who issued last cycle's access, so the RAM data can be steered back.
  typedef struct packed {
    logic vld;
    logic we;
    logic id;
  } rd_owner_t;

endpackage

// File: rtl/arb_fairness.sv
// Starvation guard for the debug port: counts consecutive refused debug
// cycles and raises force_dbg once the count reaches MAX_WAIT.
module arb_fairness
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic force_dbg
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // Count refused debug cycles, saturating; any grant or dropped request clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (dbg_gnt || !dbg_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign force_dbg = dbg_req && (wait_cnt == WAIT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU (fixed priority) and the
// debug/loader port (lock bursts plus starvation protection).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int DW       = DW_DEFAULT,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);

  owner_e        state;
  rd_owner_t     rd_owner;
  logic          force_dbg;
  logic          req_we;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_q;

  arb_fairness #(
    .MAX_WAIT (MAX_WAIT)
  ) u_fairness (
    .clk       (clk),
    .rst       (rst),
    .dbg_req   (dbg_req),
    .dbg_gnt   (dbg_gnt),
    .force_dbg (force_dbg)
  );

  // Grant decision: debug lock, then forced debug, then CPU, then debug.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (state == DBG_OWN && dbg_lock && dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (force_dbg) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // RAM port mux; the address parks on its last value when nobody is granted.
  always_comb begin
    ram_address = addr_q;
    ram_data    = dbg_wdata;
    req_we      = 1'b0;
    if (cpu_gnt) begin
      ram_address = cpu_addr;
      ram_data    = cpu_wdata;
      req_we      = cpu_we;
    end else if (dbg_gnt) begin
      ram_address = dbg_addr;
      ram_data    = dbg_wdata;
      req_we      = dbg_we;
    end
  end

  assign ram_wren = req_we & (cpu_gnt | dbg_gnt);

  // Owner of the previous cycle, used by the lock rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (cpu_gnt) begin
      state <= CPU_OWN;
    end else if (dbg_gnt) begin
      state <= DBG_OWN;
    end else begin
      state <= IDLE;
    end
  end

  // Remember the issued access so its read data can be returned next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner <= '0;
      addr_q   <= '0;
    end else begin
      rd_owner.vld <= cpu_gnt | dbg_gnt;
      rd_owner.we  <= req_we;
      rd_owner.id  <= dbg_gnt ? REQ_DBG : REQ_CPU;
      addr_q       <= ram_address;
    end
  end

  // Return path: rvalid is masked during reset so an in-flight read is dropped.
  assign cpu_rvalid = ~rst & rd_owner.vld & ~rd_owner.we & (rd_owner.id == REQ_CPU);
  assign dbg_rvalid = ~rst & rd_owner.vld & ~rd_owner.we & (rd_owner.id == REQ_DBG);
  assign cpu_rdata  = cpu_rvalid ? ram_q : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? ram_q : dbg_rdata_q;

  // Each port's read data holds until that port receives a new read.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_rdata_q <= cpu_rdata;
      dbg_rdata_q <= dbg_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model, a rule-level reference model of the
// arbitration, directed scenarios and a randomized run.
module tb_mem_arbiter;

  localparam int AW       = 12;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_wren;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Synchronous single-port RAM driven by the arbiter.
  logic [DW-1:0] ram [0:4095];
  always @(posedge clk) begin
    if (ram_wren) ram[ram_address] <= ram_data;
    ram_q <= ram[ram_address];
  end

  // Reference model state.
  logic [DW-1:0] shadow [0:4095];
  int            refused;
  bit            prev_dbg;
  bit            pend_cpu, pend_dbg;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] exp_cpu_rdata, exp_dbg_rdata;
  logic [AW-1:0] last_addr;
  bit            addr_known;
  bit            g_cpu, g_dbg;
  int            checks = 0;
  int            errors = 0;
  int            guard;
  bit            got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict and compare, then advance the model at the edge.
  task automatic cycle();
    #1;
    g_cpu = 1'b0;
    g_dbg = 1'b0;
    if (!rst) begin
      if (dbg_req && ((prev_dbg && dbg_lock) || refused >= MAX_WAIT)) g_dbg = 1'b1;
      else if (cpu_req) g_cpu = 1'b1;
      else if (dbg_req) g_dbg = 1'b1;
    end
    check("cpu_gnt", 32'(cpu_gnt), 32'(g_cpu));
    check("dbg_gnt", 32'(dbg_gnt), 32'(g_dbg));
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !g_cpu));
    check("ram_wren", 32'(ram_wren), 32'((g_cpu && cpu_we) || (g_dbg && dbg_we)));
    if (g_cpu) begin
      check("ram_address", 32'(ram_address), 32'(cpu_addr));
      if (cpu_we) check("ram_data", 32'(ram_data), 32'(cpu_wdata));
    end else if (g_dbg) begin
      check("ram_address", 32'(ram_address), 32'(dbg_addr));
      if (dbg_we) check("ram_data", 32'(ram_data), 32'(dbg_wdata));
    end else if (addr_known) begin
      check("ram_address_hold", 32'(ram_address), 32'(last_addr));
    end
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(pend_cpu && !rst));
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(pend_dbg && !rst));
    if (!rst) begin
      check("cpu_rdata", 32'(cpu_rdata), 32'(pend_cpu ? pend_data : exp_cpu_rdata));
      check("dbg_rdata", 32'(dbg_rdata), 32'(pend_dbg ? pend_data : exp_dbg_rdata));
    end
    @(posedge clk);
    if (rst) begin
      refused = 0; prev_dbg = 1'b0; pend_cpu = 1'b0; pend_dbg = 1'b0;
      exp_cpu_rdata = '0; exp_dbg_rdata = '0; last_addr = '0; addr_known = 1'b1;
    end else begin
      if (pend_cpu) exp_cpu_rdata = pend_data;
      if (pend_dbg) exp_dbg_rdata = pend_data;
      pend_cpu = g_cpu && !cpu_we;
      pend_dbg = g_dbg && !dbg_we;
      if (g_cpu) begin
        last_addr = cpu_addr;
        if (cpu_we) shadow[cpu_addr] = cpu_wdata; else pend_data = shadow[cpu_addr];
      end else if (g_dbg) begin
        last_addr = dbg_addr;
        if (dbg_we) shadow[dbg_addr] = dbg_wdata; else pend_data = shadow[dbg_addr];
      end
      if (dbg_req && !g_dbg) refused = (refused + 1 > MAX_WAIT) ? MAX_WAIT : refused + 1;
      else refused = 0;
      prev_dbg = g_dbg;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = 16'(i * 37 + 5);
      shadow[i] = 16'(i * 37 + 5);
    end
    ram[12'h010] = 16'hBEEF;
    shadow[12'h010] = 16'hBEEF;
    refused = 0; prev_dbg = 1'b0; pend_cpu = 1'b0; pend_dbg = 1'b0;
    pend_data = '0; exp_cpu_rdata = '0; exp_dbg_rdata = '0;
    last_addr = '0; addr_known = 1'b0;
    rst = 1'b1;
    idle_inputs();
    cpu_addr = '0; cpu_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
    @(negedge clk);
    cycle();
    cycle();

    // Reset state
    rst = 1'b0;
    #1;
    check("reset_addr", 32'(ram_address), 32'h0);
    check("reset_cpu_rdata", 32'(cpu_rdata), 32'h0);
    cycle();

    // CPU read of 0x010
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    cycle();
    idle_inputs();
    #1;
    check("tp_cpu_read_rvalid", 32'(cpu_rvalid), 32'd1);
    check("tp_cpu_read_rdata", 32'(cpu_rdata), 32'hBEEF);
    cycle();

    // Debug write 0x020 then CPU read of it
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h020; dbg_wdata = 16'h1234;
    #1;
    check("tp_dbg_write_wren", 32'(ram_wren), 32'd1);
    cycle();
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 12'h020;
    #1;
    check("tp_wren_pulse_end", 32'(ram_wren), 32'd0);
    cycle();
    idle_inputs();
    #1;
    check("tp_readback", 32'(cpu_rdata), 32'h1234);
    cycle();

    // Contention: debug forced every fifth cycle
    cpu_req = 1'b1; cpu_addr = 12'h040; dbg_req = 1'b1; dbg_addr = 12'h041;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("tp_starve_dbg", 32'(dbg_gnt), 32'(k % 5 == 4));
      check("tp_starve_stall", 32'(cpu_stall), 32'(k % 5 == 4));
      cycle();
    end

    // Lock burst of three debug reads
    dbg_lock = 1'b1; dbg_addr = 12'h000; cpu_addr = 12'h100;
    got = 1'b0; guard = 0;
    while (!got && guard < 10) begin
      guard++;
      cycle();
      if (g_dbg) got = 1'b1;
    end
    check("tp_lock_start", 32'(got), 32'd1);
    for (int n = 1; n < 3; n++) begin
      dbg_addr = AW'(n);
      #1;
      check("tp_lock_gnt", 32'(dbg_gnt), 32'd1);
      check("tp_lock_stall", 32'(cpu_stall), 32'd1);
      cycle();
    end
    dbg_req = 1'b0; dbg_lock = 1'b0;
    #1;
    check("tp_lock_release", 32'(cpu_gnt), 32'd1);
    cycle();

    // Reset in the cycle after a CPU read grant
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 12'h030;
    cycle();
    rst = 1'b1; cpu_we = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
    #1;
    check("tp_rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("tp_rst_wren", 32'(ram_wren), 32'd0);
    check("tp_rst_rvalid", 32'(cpu_rvalid), 32'd0);
    cycle();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("tp_rst_no_rvalid", 32'(cpu_rvalid), 32'd0);
    cycle();
    cpu_req = 1'b1; dbg_req = 1'b1; dbg_lock = 1'b1;
    #1;
    check("tp_rst_state_idle", 32'(cpu_gnt), 32'd1);
    cycle();

    // Idle hold after an access to 0x0AB
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 12'h0AB;
    cycle();
    idle_inputs();
    cycle();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("tp_idle_addr", 32'(ram_address), 32'h0AB);
      check("tp_idle_wren", 32'(ram_wren), 32'd0);
      check("tp_idle_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
      cycle();
    end

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 63) == 0);
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = ($urandom_range(0, 3) == 0);
      cpu_addr  = AW'($urandom_range(0, 15));
      cpu_wdata = DW'($urandom);
      dbg_req   = ($urandom_range(0, 1) != 0);
      dbg_we    = ($urandom_range(0, 2) == 0);
      dbg_addr  = AW'($urandom_range(0, 15));
      dbg_wdata = DW'($urandom);
      dbg_lock  = ($urandom_range(0, 2) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
